// File: rtl/sm3_pad_pkg.sv
// sm3_pad_pkg: shared state encoding, block constants and byte-count helpers for the SM3 padder
package sm3_pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAD10,
    ST_PAD00,
    ST_LENHI,
    ST_LENLO,
    ST_DONE
  } pad_state_e;

  localparam int          SM3_BLK_WORDS   = 16;
  localparam int          SM3_LEN_WORD_HI = 14;
  localparam logic [31:0] SM3_PAD10_WORD  = 32'h8000_0000;

  function automatic logic [2:0] nib_cnt(input logic [3:0] v);
    nib_cnt = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [3:0] byte_cnt(input logic [7:0] vb);
    byte_cnt = {1'b0, nib_cnt(vb[7:4])} + {1'b0, nib_cnt(vb[3:0])};
  endfunction

endpackage

// File: rtl/sm3_pad_gbox.sv
// sm3_pad_gbox: 64-to-32 gearbox; passes the high half through and holds the low half for the next transfer
// Ports: d_i/vb_i/lst_i masked beat and flags; acc_i beat accepted; take_i held half consumed;
//        w_o/nb_o/wl_o current source word, its valid byte count and message-last flag; pend_o low half held.
module sm3_pad_gbox
  import sm3_pad_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] d_i,
  input  logic [7:0]  vb_i,
  input  logic        lst_i,
  input  logic        acc_i,
  input  logic        take_i,
  output logic [31:0] w_o,
  output logic [2:0]  nb_o,
  output logic        wl_o,
  output logic        pend_o
);

  logic [31:0] lo_w_q;
  logic [2:0]  lo_nb_q;
  logic        lo_lst_q, pend_q;

  // An empty low half on the final beat is dropped; the high half then closes the message.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= 1'b0;
      lo_w_q   <= '0;
      lo_nb_q  <= '0;
      lo_lst_q <= 1'b0;
    end else if (acc_i && vb_i[3:0] != 4'd0) begin
      pend_q   <= 1'b1;
      lo_w_q   <= d_i[31:0];
      lo_nb_q  <= nib_cnt(vb_i[3:0]);
      lo_lst_q <= lst_i;
    end else if (take_i) begin
      pend_q <= 1'b0;
    end
  end

  always_comb begin
    pend_o = pend_q;
    w_o    = pend_q ? lo_w_q : d_i[63:32];
    nb_o   = pend_q ? lo_nb_q : nib_cnt(vb_i[7:4]);
    wl_o   = pend_q ? lo_lst_q : lst_i && vb_i[3:0] == 4'd0;
  end

endmodule

// File: rtl/sm3_pad_gen.sv
// sm3_pad_gen: SM3 message padder, 32/64-bit byte-masked beats in, 16 padded 32-bit words per block out
// Ports: clk, rst (sync, active-high); msg_inpt_* beat, byte-valid mask, vld/lst and rdy handshake;
//        pad_otpt_* registered word, vld, ena backpressure, block-last and message-last flags;
//        pad_err sticky framing error, present only when SM3_PAD_ERR_CHK_EN is defined.
module sm3_pad_gen
  import sm3_pad_pkg::*;
#(
  parameter int INPT_DW     = 32,
  parameter int INPT_BYTE_W = INPT_DW / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPT_DW-1:0]     msg_inpt_d,
  input  logic [INPT_BYTE_W-1:0] msg_inpt_vld_byte,
  input  logic                   msg_inpt_vld,
  input  logic                   msg_inpt_lst,
  output logic                   msg_inpt_rdy,
  output logic [31:0]            pad_otpt_d,
  output logic                   pad_otpt_vld,
  input  logic                   pad_otpt_ena,
  output logic                   pad_otpt_blk_lst,
`ifdef SM3_PAD_ERR_CHK_EN
  output logic                   pad_otpt_msg_lst,
  output logic                   pad_err
`else
  output logic                   pad_otpt_msg_lst
`endif
);

  pad_state_e       state_q;
  logic [3:0]       wcnt_q;
  logic [63:0]      bitcnt_q;
  logic [31:0]      word_q, word_d, src_w;
  logic [2:0]       src_nb;
  logic             vld_q, blk_q, msg_q, gen_d;
  logic             free, in_data, pend, acc, take, src_v, src_wl, at13;
  logic [INPT_DW-1:0] dm;

  for (genvar b = 0; b < INPT_BYTE_W; b++) begin : g_mask
    assign dm[8*b+:8] = msg_inpt_d[8*b+:8] & {8{msg_inpt_vld_byte[b]}};
  end

  if (INPT_DW == 64) begin : g_gbox
    sm3_pad_gbox u_gbox (
      .clk    (clk),
      .rst    (rst),
      .d_i    (dm),
      .vb_i   (msg_inpt_vld_byte),
      .lst_i  (msg_inpt_lst),
      .acc_i  (acc),
      .take_i (take),
      .w_o    (src_w),
      .nb_o   (src_nb),
      .wl_o   (src_wl),
      .pend_o (pend)
    );
  end else begin : g_byp
    assign src_w  = dm;
    assign src_nb = nib_cnt(msg_inpt_vld_byte);
    assign src_wl = msg_inpt_lst;
    assign pend   = 1'b0;
  end

  // wcnt_q is the block index of the next word loaded into the output register.
  // A final source word always gets the 0x80 marker after its valid bytes; a full word shifts it out.
  always_comb begin
    free         = !vld_q || pad_otpt_ena;
    in_data      = state_q == ST_IDLE || state_q == ST_DATA;
    msg_inpt_rdy = !rst && in_data && !pend && free;
    acc          = msg_inpt_vld && msg_inpt_rdy;
    take         = pend && free;
    src_v        = acc || take;
    at13         = wcnt_q == 4'(SM3_LEN_WORD_HI - 1);
    gen_d        = in_data ? src_v : state_q != ST_DONE;
    word_d       = in_data ? (src_wl ? src_w | (SM3_PAD10_WORD >> {src_nb, 3'b000}) : src_w) :
                   state_q == ST_PAD10 ? SM3_PAD10_WORD :
                   state_q == ST_LENHI ? bitcnt_q[63:32] :
                   state_q == ST_LENLO ? bitcnt_q[31:0] : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      bitcnt_q <= '0;
      word_q   <= '0;
      vld_q    <= 1'b0;
      blk_q    <= 1'b0;
      msg_q    <= 1'b0;
    end else begin
      if (acc) bitcnt_q <= bitcnt_q + {57'd0, byte_cnt(8'(msg_inpt_vld_byte)), 3'b000};
      if (free) begin
        vld_q  <= gen_d;
        word_q <= gen_d ? word_d : 32'd0;
        blk_q  <= gen_d && wcnt_q == 4'(SM3_BLK_WORDS - 1);
        msg_q  <= gen_d && state_q == ST_LENLO;
        if (gen_d) wcnt_q <= wcnt_q + 4'd1;
        case (state_q)
          ST_IDLE, ST_DATA: if (src_v) state_q <= !src_wl ? ST_DATA :
                                                  src_nb == 3'd4 ? ST_PAD10 :
                                                  at13 ? ST_LENHI : ST_PAD00;
          ST_PAD10, ST_PAD00: state_q <= at13 ? ST_LENHI : ST_PAD00;
          ST_LENHI: state_q <= ST_LENLO;
          ST_LENLO: state_q <= ST_DONE;
          default: begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign pad_otpt_d       = word_q;
  assign pad_otpt_vld     = vld_q;
  assign pad_otpt_blk_lst = blk_q;
  assign pad_otpt_msg_lst = msg_q;

`ifdef SM3_PAD_ERR_CHK_EN
  // A contiguous MSB-first mask inverts to 0..01..1, so inverse & (inverse + 1) must be zero.
  logic [INPT_BYTE_W-1:0] inv_vb, inv_inc;
  logic                   err_q;
  assign inv_vb  = ~msg_inpt_vld_byte;
  assign inv_inc = inv_vb + INPT_BYTE_W'(1);
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (acc && ((inv_vb & inv_inc) != '0 || (!msg_inpt_lst && inv_vb != '0))) err_q <= 1'b1;
  end
  assign pad_err = err_q;
`endif

endmodule

// File: tb/tb_sm3_pad_gen.sv
// tb_sm3_pad_gen: directed bench for the SM3 padder with a 32-bit and a 64-bit instance
module tb_sm3_pad_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a_d = '0;
  logic [3:0]  a_vb = '0;
  logic        a_vld = 1'b0, a_lst = 1'b0, a_ena = 1'b1, a_rdy, a_pv, a_bl, a_ml;
  logic [31:0] a_pd;
  logic [63:0] b_d = '0;
  logic [7:0]  b_vb = '0;
  logic        b_vld = 1'b0, b_lst = 1'b0, b_ena = 1'b1, b_rdy, b_pv, b_bl, b_ml;
  logic [31:0] b_pd;

  int checks = 0;
  int failures = 0;
  logic [33:0] qa[$];
  logic [33:0] qb[$];
  logic [33:0] exp_q[$];
  logic [31:0] snap;

  sm3_pad_gen #(.INPT_DW(32)) dut_a (
    .clk(clk), .rst(rst), .msg_inpt_d(a_d), .msg_inpt_vld_byte(a_vb), .msg_inpt_vld(a_vld),
    .msg_inpt_lst(a_lst), .msg_inpt_rdy(a_rdy), .pad_otpt_d(a_pd), .pad_otpt_vld(a_pv),
    .pad_otpt_ena(a_ena), .pad_otpt_blk_lst(a_bl), .pad_otpt_msg_lst(a_ml)
  );

  sm3_pad_gen #(.INPT_DW(64)) dut_b (
    .clk(clk), .rst(rst), .msg_inpt_d(b_d), .msg_inpt_vld_byte(b_vb), .msg_inpt_vld(b_vld),
    .msg_inpt_lst(b_lst), .msg_inpt_rdy(b_rdy), .pad_otpt_d(b_pd), .pad_otpt_vld(b_pv),
    .pad_otpt_ena(b_ena), .pad_otpt_blk_lst(b_bl), .pad_otpt_msg_lst(b_ml)
  );

  // Record every transferred word {msg_lst, blk_lst, data}, sampled mid low phase.
  always @(negedge clk) begin
    #3;
    if (a_pv && a_ena) qa.push_back({a_ml, a_bl, a_pd});
    if (b_pv && b_ena) qb.push_back({b_ml, b_bl, b_pd});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add(input logic [31:0] w, input int n, input logic m);
    repeat (n) exp_q.push_back({m, 1'((exp_q.size() % 16) == 15), w});
  endtask

  task automatic send_a(input logic [31:0] d, input logic [3:0] vb, input logic lst);
    int n = 0;
    @(negedge clk);
    a_d = d; a_vb = vb; a_lst = lst; a_vld = 1'b1;
    #3;
    while (!a_rdy && n < 100) begin @(negedge clk); #3; n++; end
    if (n >= 100) chk("a_rdy_timeout", 64'(n), 64'd0);
  endtask

  task automatic send_b(input logic [63:0] d, input logic [7:0] vb, input logic lst);
    int n = 0;
    @(negedge clk);
    b_d = d; b_vb = vb; b_lst = lst; b_vld = 1'b1;
    #3;
    while (!b_rdy && n < 100) begin @(negedge clk); #3; n++; end
    if (n >= 100) chk("b_rdy_timeout", 64'(n), 64'd0);
  endtask

  task automatic idle;
    @(negedge clk);
    a_vld = 1'b0; a_lst = 1'b0; b_vld = 1'b0; b_lst = 1'b0;
  endtask

  task automatic wait_words(input logic is_b, input int cnt);
    int n = 0;
    while ((is_b ? qb.size() : qa.size()) < cnt && n < 400) begin @(negedge clk); n++; end
  endtask

  task automatic run_cmp(input string tag, input logic is_b);
    wait_words(is_b, exp_q.size());
    repeat (4) @(negedge clk);
    chk({tag, "_len"}, 64'(is_b ? qb.size() : qa.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 64'(is_b ? qb[i] : qa[i]), 64'(exp_q[i]));
    qa.delete(); qb.delete(); exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #3;
    chk("rst_a_vld", 64'(a_pv), 0); chk("rst_a_d", 64'(a_pd), 0); chk("rst_a_rdy", 64'(a_rdy), 0);
    chk("rst_a_flags", 64'({a_bl, a_ml}), 0); chk("rst_b_vld", 64'(b_pv), 0); chk("rst_b_rdy", 64'(b_rdy), 0);
    @(negedge clk); rst = 1'b0;
    #3; chk("idle_a_rdy", 64'(a_rdy), 1);

    // 'abc' on the 32-bit instance
    send_a(32'h6162_6300, 4'b1110, 1'b1); idle;
    add(32'h6162_6380, 1, 0); add(0, 14, 0); add(32'h18, 1, 1);
    run_cmp("abc32", 1'b0);

    // 'abc' on the 64-bit instance, junk in masked bytes
    send_b(64'h6162_63FF_DEAD_BEEF, 8'b1110_0000, 1'b1); idle;
    add(32'h6162_6380, 1, 0); add(0, 14, 0); add(32'h18, 1, 1);
    run_cmp("abc64", 1'b1);

    // 12 bytes on 64-bit: empty low half dropped, rdy low while a low half is pending
    send_b(64'h6162_6364_6566_6768, 8'hFF, 1'b0);
    @(negedge clk); #3; chk("gb_rdy_pend", 64'(b_rdy), 0);
    send_b(64'h696A_6B6C_1234_5678, 8'hF0, 1'b1); idle;
    add(32'h6162_6364, 1, 0); add(32'h6566_6768, 1, 0); add(32'h696A_6B6C, 1, 0);
    add(32'h8000_0000, 1, 0); add(0, 11, 0); add(32'h60, 1, 1);
    run_cmp("b12", 1'b1);

    // 64 bytes: second block carries only padding and length
    for (int i = 0; i < 16; i++) send_a(32'h6162_6364, 4'hF, 1'(i == 15));
    idle;
    add(32'h6162_6364, 16, 0); add(32'h8000_0000, 1, 0); add(0, 14, 0); add(32'h200, 1, 1);
    run_cmp("m64", 1'b0);

    // 56 bytes: 0x80 lands at word 14, a full extra block follows
    for (int i = 0; i < 14; i++) send_a(32'h6162_6364, 4'hF, 1'(i == 13));
    idle;
    add(32'h6162_6364, 14, 0); add(32'h8000_0000, 1, 0); add(0, 1, 0);
    add(0, 15, 0); add(32'h1C0, 1, 1);
    run_cmp("m56", 1'b0);

    // empty message, junk data masked away
    send_a(32'hDEAD_BEEF, 4'b0000, 1'b1); idle;
    add(32'h8000_0000, 1, 0); add(0, 15, 0);
    exp_q.pop_back(); add(0, 1, 1);
    run_cmp("empty", 1'b0);

    // backpressure for 3 cycles in the middle of the padding
    send_a(32'h6162_6364, 4'hF, 1'b0); send_a(32'h6566_6768, 4'hF, 1'b1); idle;
    wait_words(1'b0, 5);
    @(negedge clk); a_ena = 1'b0;
    #3; snap = a_pd;
    chk("bp_vld0", 64'(a_pv), 1); chk("bp_rdy0", 64'(a_rdy), 0);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk); #3;
      chk($sformatf("bp_d%0d", i), 64'(a_pd), 64'(snap));
      chk($sformatf("bp_vld%0d", i), 64'(a_pv), 1);
    end
    @(negedge clk); a_ena = 1'b1;
    add(32'h6162_6364, 1, 0); add(32'h6566_6768, 1, 0); add(32'h8000_0000, 1, 0);
    add(0, 12, 0); add(32'h40, 1, 1);
    run_cmp("bp", 1'b0);

    // reset mid-message, then a clean 'abc'
    for (int i = 0; i < 5; i++) send_a(32'h6162_6364, 4'hF, 1'b0);
    @(negedge clk); a_vld = 1'b0; rst = 1'b1;
    #3; chk("mid_vld_pre", 64'(a_pv), 1);
    @(negedge clk); #3;
    chk("mid_rst_vld", 64'(a_pv), 0); chk("mid_rst_d", 64'(a_pd), 0);
    chk("mid_rst_flags", 64'({a_bl, a_ml}), 0); chk("mid_rst_rdy", 64'(a_rdy), 0);
    @(negedge clk); rst = 1'b0;
    qa.delete();
    send_a(32'h6162_6377, 4'b1110, 1'b1); idle;
    add(32'h6162_6380, 1, 0); add(0, 14, 0); add(32'h18, 1, 1);
    run_cmp("post_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
